// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle between the EX-stage control unit and the mul/div unit.
// Latency: none, wires only.
// Backpressure: none here; the master must hold off while busy is high.
//   master: start, op, flush, a, b -> ; <- busy, done, dz, hi, lo
//   slave : the mirror image, used by muldiv_unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, flush, a, b,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, flush, a, b,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Latency: mul/div write hi/lo WIDTH+1 edges after the start edge; MTHI/MTLO at the start edge.
// Backpressure: busy high while an op is in flight; start is ignored until busy drops.
//
// Ports: clk, reset (synchronous, active-high), bus (muldiv_unit_if.slave):
//   start/op/flush/a/b in; busy/done/dz/hi/lo out.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply with a
//   single-cycle array multiply (IDLE -> FIX, result one edge after start).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               qneg_q;   // negate product / quotient
    logic               rneg_q;   // negate remainder (sign of a)
    logic               bzero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dz_q;

    // Operand preparation for the launch edge
    logic               op_md;
    logic               launch;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign op_md  = ~bus.op[2];
    assign launch = (state == IDLE) && bus.start && op_md;
    assign a_neg  = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg  = ~bus.op[0] & bus.b[WIDTH-1];
    assign mag_a  = a_neg ? -bus.a : bus.a;
    assign mag_b  = b_neg ? -bus.b : bus.b;

    // One radix-2 step of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_rsh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_acc;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_acc  = {mul_sum, acc[WIDTH-1:1]};
    // The shifted remainder can need WIDTH+1 bits when the divisor is near 2^WIDTH.
    assign div_rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_rsh - {1'b0, opnd};
    assign div_acc  = div_diff[WIDTH]
                    ? {div_rsh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign prod = qneg_q ? -acc : acc;
    assign quo  = qneg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero: remainder magnitude is |a|, so rem already restores a.
            res_hi = rem;
            res_lo = bzero_q ? {WIDTH{1'b1}} : quo;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = bus.op[1] ? RUN : FIX;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (bus.flush)                    state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))   state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt      <= '0;
                        is_div_q <= bus.op[1];
                        qneg_q   <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        bzero_q  <= (bus.b == '0);
                        if (bus.op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc  <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
`endif
                        end
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_q   <= bus.a;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_q   <= bus.a;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        acc <= is_div_q ? div_acc : mul_acc;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        dz_q   <= is_div_q & bzero_q;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 with hand-computed results.
// Latency: checks done timing against the start edge for each op.
// Backpressure: exercises ignored start while busy and flush of an op in flight.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launch an op at the current falling edge and wait for done.
    // lat = index k of the edge E(k) that raised done (E0 = start edge), -1 if done never rises.
    // poke: 1 = second start at iteration poke_at, 2 = flush at iteration poke_at.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input int poke_at,
                          output int lat, output logic busy0);
        lat   = -1;
        busy0 = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = 1'b0;
            if (i == 0) busy0 = bus.busy;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (poke == 1 && i == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 3'b001;
                bus.a     = 32'd3;
                bus.b     = 32'd3;
            end
            if (poke == 2 && i == poke_at) bus.flush = 1'b1;
        end
    endtask

    int   lat;
    logic busy0;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz",   64'(bus.dz),   64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULT -1 * 2
        run_op(3'b000, 32'hFFFF_FFFF, 32'd2, 0, 0, lat, busy0);
        chk("mult_lat",  64'(lat),    64'(MUL_LAT));
        chk("mult_busy", 64'(busy0),  64'd1);
        chk("mult_hi",   64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo",   64'(bus.lo), 64'hFFFF_FFFE);
        chk("mult_dz",   64'(bus.dz), 64'd0);

        // MULTU 0xFFFFFFFF * 2, issued in the done cycle
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 0, 0, lat, busy0);
        chk("multu_lat", 64'(lat),    64'(MUL_LAT));
        chk("multu_hi",  64'(bus.hi), 64'h1);
        chk("multu_lo",  64'(bus.lo), 64'hFFFF_FFFE);
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);

        // MULT -3 * -4 = 12
        run_op(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0, 0, lat, busy0);
        chk("mult_nn_hi", 64'(bus.hi), 64'h0);
        chk("mult_nn_lo", 64'(bus.lo), 64'hC);

        // DIV -7 / 2 = -3 rem -1
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, busy0);
        chk("div_lat", 64'(lat),    64'(DIV_LAT));
        chk("div_lo",  64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi",  64'(bus.hi), 64'hFFFF_FFFF);

        // DIV most-negative / -1 wraps
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, busy0);
        chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.hi), 64'h0);

        // DIV 7 / -2 = -3 rem 1
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE, 0, 0, lat, busy0);
        chk("div_pn_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_pn_hi", 64'(bus.hi), 64'h1);

        // DIVU by zero
        run_op(3'b011, 32'd100, 32'd0, 0, 0, lat, busy0);
        chk("divz_lat", 64'(lat),    64'(DIV_LAT));
        chk("divz_lo",  64'(bus.lo), 64'hFFFF_FFFF);
        chk("divz_hi",  64'(bus.hi), 64'd100);
        chk("divz_dz",  64'(bus.dz), 64'd1);

        // MTLO back-to-back in the done cycle
        run_op(3'b101, 32'd5, 32'd0, 0, 0, lat, busy0);
        chk("mtlo_lat",  64'(lat),    64'd0);
        chk("mtlo_busy", 64'(busy0),  64'd0);
        chk("mtlo_lo",   64'(bus.lo), 64'd5);
        chk("mtlo_hi",   64'(bus.hi), 64'd100);
        chk("mtlo_dz",   64'(bus.dz), 64'd0);

        // MTHI leaves lo alone
        run_op(3'b100, 32'h0000_ABCD, 32'd0, 0, 0, lat, busy0);
        chk("mthi_hi", 64'(bus.hi), 64'h0000_ABCD);
        chk("mthi_lo", 64'(bus.lo), 64'd5);

        // Reserved op: nothing happens
        run_op(3'b110, 32'h1234_5678, 32'd9, 0, 0, lat, busy0);
        chk("rsv_lat",  64'(lat),      64'hFFFF_FFFF_FFFF_FFFF);
        chk("rsv_busy", 64'(bus.busy), 64'd0);
        chk("rsv_hi",   64'(bus.hi),   64'h0000_ABCD);
        chk("rsv_lo",   64'(bus.lo),   64'd5);

        // DIVU 100/7 with a start attempt while busy
        run_op(3'b011, 32'd100, 32'd7, 1, 2, lat, busy0);
        chk("ign_lat", 64'(lat),    64'(DIV_LAT));
        chk("ign_lo",  64'(bus.lo), 64'd14);
        chk("ign_hi",  64'(bus.hi), 64'd2);

        // DIVU 50/3 flushed mid-run
        run_op(3'b011, 32'd50, 32'd3, 2, 9, lat, busy0);
        chk("flush_lat",  64'(lat),      64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_lo",   64'(bus.lo),   64'd14);
        chk("flush_hi",   64'(bus.hi),   64'd2);
        chk("flush_dz",   64'(bus.dz),   64'd0);

        // Fast-path vector; correct in both builds, latency differs
        run_op(3'b000, 32'd3, 32'hFFFF_FFFC, 0, 0, lat, busy0);
        chk("m34_lat", 64'(lat),    64'(MUL_LAT));
        chk("m34_lo",  64'(bus.lo), 64'hFFFF_FFF4);
        chk("m34_hi",  64'(bus.hi), 64'hFFFF_FFFF);

        // Reset in the middle of a MULT
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_busy", 64'(bus.busy), 64'd0);
        chk("rmid_done", 64'(bus.done), 64'd0);
        chk("rmid_hi",   64'(bus.hi),   64'd0);
        chk("rmid_lo",   64'(bus.lo),   64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("rmid_nodone", 64'(bus.done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
